// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared constants for the pipeline stage controller: FSM encodings,
// stage indices and the drain-length helper.
package pipeline_stage_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Instructions already past ID need one cycle per remaining stage to retire.
    function automatic int drain_len(input int num_stages);
        return num_stages - 2;
    endfunction

endpackage

// File: rtl/pipeline_stage_ctrl_if.sv
// Debug/hazard request inputs and stage-control outputs of the controller.
interface pipeline_stage_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  i_run;
    logic                  i_step;
    logic                  i_halt;
    logic                  i_hazard_stall;
    logic                  i_jump;
    logic                  i_program_end;
    logic [NUM_STAGES-1:0] o_stage_enable;
    logic [NUM_STAGES-1:0] o_stage_flush;
    logic [2:0]            o_state;
    logic                  o_done;
    logic [CNT_WIDTH-1:0]  o_cycle_count;

    modport master (
        output i_run, i_step, i_halt, i_hazard_stall, i_jump, i_program_end,
        input  o_stage_enable, o_stage_flush, o_state, o_done, o_cycle_count
    );

    modport slave (
        input  i_run, i_step, i_halt, i_hazard_stall, i_jump, i_program_end,
        output o_stage_enable, o_stage_flush, o_state, o_done, o_cycle_count
    );
endinterface

// File: rtl/pipeline_stage_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Pipeline stage controller: run/step/drain sequencing for the debug unit,
// with per-stage enables and bubble inserts for hazards and jumps.
module pipeline_stage_ctrl
    import pipeline_stage_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CNT_WIDTH  = 32
) (
    input logic                  i_clk,
    input logic                  i_reset,
    pipeline_stage_ctrl_if.slave bus
);

    localparam int DRAIN_LEN = drain_len(NUM_STAGES);

    logic [2:0]            state_r;
    logic [2:0]            next_state_s;
    logic [3:0]            drain_cnt_r;
    logic                  done_r;
    logic [NUM_STAGES-1:0] enable_s;
    logic [NUM_STAGES-1:0] flush_s;
    logic [CNT_WIDTH-1:0]  cycle_count_s;

    // Next-state selection and combinational stage enable/flush pattern.
    always_comb begin
        next_state_s = state_r;
        enable_s     = '0;
        flush_s      = '0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_halt) begin
                    next_state_s = ST_IDLE;
                end else if (bus.i_run) begin
                    next_state_s = ST_RUN;
                end else if (bus.i_step) begin
                    next_state_s = ST_STEP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STEP: begin
                enable_s = '1;
                // A stall bubble in EX supersedes killing the wrong-path ID slot.
                if (bus.i_hazard_stall) begin
                    enable_s[STG_IF] = 1'b0;
                    enable_s[STG_ID] = 1'b0;
                    flush_s[STG_EX]  = 1'b1;
                end else if (bus.i_jump) begin
                    flush_s[STG_ID]  = 1'b1;
                end else begin
                    flush_s = '0;
                end
                if (bus.i_halt) begin
                    next_state_s = ST_IDLE;
                end else if (bus.i_program_end) begin
                    next_state_s = ST_DRAIN;
                end else if (state_r == ST_STEP) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                enable_s         = '1;
                enable_s[STG_IF] = 1'b0;
                enable_s[STG_ID] = 1'b0;
                if (drain_cnt_r == 4'd0) begin
                    flush_s[STG_EX] = 1'b1;
                end else begin
                    flush_s = '0;
                end
                if (drain_cnt_r == 4'(DRAIN_LEN - 1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        if (i_reset) begin
            next_state_s = ST_IDLE;
            enable_s     = '0;
            flush_s      = '0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State, drain progress and done flag registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= 4'd0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            drain_cnt_r <= ((state_r == ST_DRAIN) && (next_state_s == ST_DRAIN))
                           ? drain_cnt_r + 4'd1 : 4'd0;
            done_r      <= (next_state_s == ST_DONE);
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (i_clk),
        .reset (i_reset),
        .inc   (|enable_s),
        .count (cycle_count_s)
    );

    assign bus.o_stage_enable = enable_s;
    assign bus.o_stage_flush  = flush_s;
    assign bus.o_state        = state_r;
    assign bus.o_done         = done_r;
    assign bus.o_cycle_count  = cycle_count_s;

endmodule

// File: doc/pipeline_stage_ctrl.md
PIPELINE_STAGE_CTRL -- requirements
Module: pipeline_stage_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages; index 0 = IF, NUM_STAGES-1 = WB; legal range 3..16.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the retired-cycle counter.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port i_run, input, 1, debug unit request for continuous execution.
REQ-006 SHALL have port i_step, input, 1, debug unit request to advance exactly one cycle.
REQ-007 SHALL have port i_halt, input, 1, debug unit request to freeze all stages.
REQ-008 SHALL have port i_hazard_stall, input, 1, load-use/jump-operand stall from the hazard unit.
REQ-009 SHALL have port i_jump, input, 1, jump resolved in ID; IF/ID content is wrong-path.
REQ-010 SHALL have port i_program_end, input, 1, HALT opcode decoded in ID.
REQ-011 SHALL have port o_stage_enable, output, NUM_STAGES, per-stage latch update enable.
REQ-012 SHALL have port o_stage_flush, output, NUM_STAGES, per-stage bubble insert (latch loads NOP/zero controls).
REQ-013 SHALL have port o_state, output, 3, current FSM state encoding.
REQ-014 SHALL have port o_done, output, 1, program fully retired.
REQ-015 SHALL have port o_cycle_count, output, CNT_WIDTH, count of cycles with any stage enabled.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, STEP, DRAIN, DONE.
REQ-017 IDLE: all enables 0, all flushes 0; i_run -> RUN; else i_step -> STEP; i_run and i_step together -> RUN.
REQ-018 RUN: all enables 1; i_halt -> IDLE; i_program_end -> DRAIN; i_step ignored.
REQ-019 STEP: enables as RUN for exactly one cycle, then -> IDLE; i_program_end in that cycle -> DRAIN instead.
REQ-020 Hazard stall (RUN/STEP only): enable[0]=enable[1]=0, flush[2]=1, enable[2..N-1]=1.
REQ-021 i_jump without stall (RUN/STEP): flush[1]=1; with stall, stall pattern wins, no flush.
REQ-022 DRAIN: enable[0]=enable[1]=0, flush[2]=1 on first cycle, stages 2..N-1 enabled; stays exactly NUM_STAGES-2 cycles, then -> DONE.
REQ-023 i_halt during DRAIN SHALL be ignored; drain completes free-running.
REQ-024 DONE: all enables 0, o_done=1; leaves only on reset.
REQ-025 Outputs o_stage_enable/o_stage_flush SHALL be combinational from state and inputs; o_state, o_done, o_cycle_count registered.
REQ-026 o_cycle_count SHALL increment by 1 in each cycle with any enable bit set, saturating at 2^CNT_WIDTH-1.
REQ-027 Input priority: i_reset > i_halt > i_program_end > i_run > i_step.

Reset
REQ-028 On i_reset: state IDLE, drain counter 0, o_done 0, o_cycle_count 0; enables and flushes 0 in that cycle.
REQ-029 Reset asserted mid-DRAIN or in DONE SHALL return to IDLE on the next edge with no residual count.

Structure
REQ-030 State encodings, stage index constants (IF/ID/EX/MEM/WB) and drain length function SHALL live in the shared pipeline package.
REQ-031 The saturating counter SHALL be a sub-module sat_counter (parameter WIDTH, inputs clk/reset/inc).
REQ-032 The pipeline top SHALL gate i_stall/i_halt of each stage with o_stage_enable and route o_program_end into i_program_end.

Verification
REQ-033 Reset, i_step pulse x3 -> three single cycles of enable=5'b11111, o_cycle_count=3, state IDLE.
REQ-034 RUN, i_hazard_stall 1 cycle -> enable=5'b11100, flush=5'b00100 that cycle, count increments.
REQ-035 RUN, i_jump=1 -> flush=5'b00010; i_jump with i_hazard_stall -> flush=5'b00100 only.
REQ-036 RUN, i_program_end -> DRAIN 3 cycles (NUM_STAGES=5) enable=5'b11100, then DONE, o_done=1, enables 0; NUM_STAGES=7 -> 5 drain cycles.
REQ-037 CNT_WIDTH=4, RUN 20 cycles -> o_cycle_count holds 15; i_reset mid-DRAIN -> IDLE, count 0.
